// File: rtl/mux4_rr_sel.sv
// Round-robin select generator for a downstream 4:1 mux.
// Registered one-hot grant and encoded select; owner held until release, request drop or hold limit.
module mux4_rr_sel #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_i,
    input  logic       release_i,
    output logic [1:0] sel_o,
    output logic [3:0] grant_o,
    output logic       grant_valid_o,
    output logic       timeout_o
);

    localparam logic [7:0] HoldMaxC = 8'(HOLD_MAX);
    localparam bit         LimitEn  = (HOLD_MAX != 0);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] grant_q, grant_d;
    logic       valid_q, valid_d;
    logic       timeout_q, timeout_d;

    // Returns {found, index}; search starts at p, wrapping mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            hcnt_q    <= '0;
            sel_q     <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hcnt_q    <= hcnt_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    logic       end_rel, end_drop, end_lim;
    logic [1:0] next_ptr;
    logic [2:0] pick;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hcnt_d    = hcnt_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        end_rel   = 1'b0;
        end_drop  = 1'b0;
        end_lim   = 1'b0;
        next_ptr  = ptr_q;
        pick      = '0;

        unique case (state_q)
            StIdle: begin
                pick = rr_pick(req_i, ptr_q);
                if (pick[2]) begin
                    state_d = StGrant;
                    sel_d   = pick[1:0];
                    grant_d = 4'b0001 << pick[1:0];
                    valid_d = 1'b1;
                    hcnt_d  = 8'd1;
                end
            end
            StGrant: begin
                end_rel  = release_i;
                end_drop = !req_i[sel_q];
                end_lim  = LimitEn && (hcnt_q == HoldMaxC);
                if (end_rel || end_drop || end_lim) begin
                    // Old owner rotates to lowest priority before re-arbitrating.
                    next_ptr  = sel_q + 2'd1;
                    ptr_d     = next_ptr;
                    pick      = rr_pick(req_i, next_ptr);
                    timeout_d = end_lim && !end_rel && !end_drop;
                    if (pick[2]) begin
                        sel_d   = pick[1:0];
                        grant_d = 4'b0001 << pick[1:0];
                        hcnt_d  = 8'd1;
                    end else begin
                        state_d = StIdle;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sel_o         = sel_q;
        grant_o       = grant_q;
        grant_valid_o = valid_q;
        timeout_o     = timeout_q;
    end

endmodule

// File: tb/tb_mux4_rr_sel.sv
// Directed bench for mux4_rr_sel: vector table plus hand sequences for hold limit,
// async reset and mux integration.
module tb_mux4_rr_sel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       rel;

    logic [1:0] sel15, sel4, sel0;
    logic [3:0] gnt15, gnt4, gnt0;
    logic       vld15, vld4, vld0;
    logic       to15, to4, to0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux4_rr_sel #(.HOLD_MAX(15)) u15 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .release_i(rel),
        .sel_o(sel15), .grant_o(gnt15), .grant_valid_o(vld15), .timeout_o(to15)
    );
    mux4_rr_sel #(.HOLD_MAX(4)) u4 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .release_i(rel),
        .sel_o(sel4), .grant_o(gnt4), .grant_valid_o(vld4), .timeout_o(to4)
    );
    mux4_rr_sel #(.HOLD_MAX(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .release_i(rel),
        .sel_o(sel0), .grant_o(gnt0), .grant_valid_o(vld0), .timeout_o(to0)
    );

    typedef struct {
        logic [3:0] req;
        logic       rel;
        logic [1:0] sel;
        logic [3:0] grant;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic rl);
        @(negedge clk);
        req = r;
        rel = rl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero15(input string name, input int idx);
        chk({name, "_sel"}, idx, 8'(sel15), 8'h0);
        chk({name, "_grant"}, idx, 8'(gnt15), 8'h0);
        chk({name, "_vld"}, idx, 8'(vld15), 8'h0);
        chk({name, "_to"}, idx, 8'(to15), 8'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        rel   = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [1:0] exp_sel4[13] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0,
                                 2'd0, 2'd0, 2'd0, 2'd1};
    logic       exp_to4[13]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] mux_data = 4'b0101;  // a=1, b=0, c=1, d=0
    logic       exp_y[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] exp_rot[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        vecs[0]  = '{4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        vecs[2]  = '{4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        vecs[3]  = '{4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        vecs[4]  = '{4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        vecs[5]  = '{4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        vecs[6]  = '{4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        vecs[7]  = '{4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        vecs[8]  = '{4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0};
        vecs[9]  = '{4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        vecs[10] = '{4'b1111, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0};
        vecs[11] = '{4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0};
        vecs[12] = '{4'b1111, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0};
        vecs[13] = '{4'b1111, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0};
        vecs[14] = '{4'b1111, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0};
        vecs[15] = '{4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0};
        vecs[16] = '{4'b1111, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0};
        vecs[17] = '{4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
        vecs[18] = '{4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0};
        vecs[19] = '{4'b0011, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
        vecs[20] = '{4'b0011, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};

        rst_n = 1'b0;
        req   = '0;
        rel   = 1'b0;
        #3;
        chk_zero15("rst", 0);
        #9;
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            cyc(vecs[i].req, vecs[i].rel);
            chk("tbl_sel", i, 8'(sel15), 8'(vecs[i].sel));
            chk("tbl_grant", i, 8'(gnt15), 8'(vecs[i].grant));
            chk("tbl_vld", i, 8'(vld15), 8'(vecs[i].vld));
            chk("tbl_to", i, 8'(to15), 8'(vecs[i].to));
        end

        // Async reset mid-grant: outputs clear without a clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero15("async_rst", 0);
        chk("async_rst_u4_vld", 0, 8'(vld4), 8'h0);
        #1;
        rst_n = 1'b1;

        // Hold limit: u4 rotates on timeout, u0 never times out; last cycle releases at the limit.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cyc(4'b0011, (i == 12));
            chk("hold4_sel", i, 8'(sel4), 8'(exp_sel4[i]));
            chk("hold4_to", i, 8'(to4), 8'(exp_to4[i]));
            chk("hold4_vld", i, 8'(vld4), 8'h1);
            if (i < 12) begin
                chk("hold0_sel", i, 8'(sel0), 8'h0);
                chk("hold0_to", i, 8'(to0), 8'h0);
                chk("hold0_vld", i, 8'(vld0), 8'h1);
            end
        end

        // Mux integration: a..d = 1,0,1,0 with round-robin rotation from reset.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(4'b1111, 1'b1);
            chk("rot_sel", i, 8'(sel15), 8'(exp_rot[i]));
            chk("mux_y", i, 8'(mux_data[sel15]), 8'(exp_y[i]));
            chk("onehot", i, 8'($onehot(gnt15) && vld15), 8'h1);
            chk("grant_sel", i, 8'(gnt15), 8'(4'b0001 << exp_rot[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
